// File: rtl/signed_divider_if.sv
// -----------------------------------------------------------------------------
// signed_divider_if
//   Handshake and data bundle for the sequential signed divider.
//   The master drives start, dividend and divisor. The slave (the divider)
//   returns busy, the done pulse, the held results and the status flags.
//
//   Parameters
//     DW  dividend / quotient width (two's complement)
//     VW  divisor / remainder width (two's complement)
//
//   Optional build macro: DIVIDER_BCD_OUT_EN
//     Adds quot_bcd (decimal digits of |quotient|) and quot_sign.
// -----------------------------------------------------------------------------
interface signed_divider_if #(
  parameter int DW = 10,
  parameter int VW = 5
);
`ifdef DIVIDER_BCD_OUT_EN
  // Enough decimal digits for the largest magnitude, 2^(DW-1).
  localparam int ND = ((DW - 1) * 301) / 1000 + 1;
`endif

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  logic          overflow;
`ifdef DIVIDER_BCD_OUT_EN
  logic [4*ND-1:0] quot_bcd;
  logic            quot_sign;
`endif

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
`ifdef DIVIDER_BCD_OUT_EN
    , quot_bcd, quot_sign
`endif
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
`ifdef DIVIDER_BCD_OUT_EN
    , quot_bcd, quot_sign
`endif
  );
endinterface

// File: rtl/signed_divider.sv
// -----------------------------------------------------------------------------
// signed_divider
//   Sequential signed restoring divider. It produces one quotient bit per
//   clock, MSB first, on operand magnitudes and applies the signs at the end.
//   The quotient truncates toward zero and the remainder takes the sign of the
//   dividend, so dividend == quotient*divisor + remainder.
//   Results and flags are registered and held until the next done.
//
//   Ports
//     clk  single clock, rising edge
//     rst  synchronous reset, active-low
//     bus  signed_divider_if.slave:
//            start/dividend/divisor in; busy, done (1-cycle pulse), quotient,
//            remainder, div_zero and overflow out
//
//   Latency: start is captured at edge 1. busy is high after edges 1..DW+1,
//   and done is high after edge DW+2. The latency is the same for every
//   operand value, including a zero divisor.
//
//   Optional build macro: DIVIDER_BCD_OUT_EN
//     Adds a BCD state that converts |quotient| with shift-add-3 over DW
//     cycles, and drives quot_bcd / quot_sign. With the macro, done arrives
//     after edge 2*DW+2.
// -----------------------------------------------------------------------------
module signed_divider #(
  parameter int DW = 10,
  parameter int VW = 5
) (
  input  logic            clk,
  input  logic            rst,
  signed_divider_if.slave bus
);
  localparam int CW = $clog2(DW);
  // Partial remainder carries one extra bit so a divisor magnitude of
  // 2^(VW-1) still fits after the shift.
  localparam int RW = VW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_BCD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Dividend magnitude shifts out of the top while quotient bits shift in.
  logic [DW-1:0] dq_q, dq_d;
  logic [VW-1:0] dmag_q, dmag_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          neg_quot_q, neg_quot_d;
  logic          neg_rem_q, neg_rem_d;
  logic          done_q, done_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          div_zero_q, div_zero_d;
  logic          overflow_q, overflow_d;

  // Datapath for one restoring step.
  logic [RW:0]   shifted;
  logic          take;
  assign shifted = {rem_q, dq_q[DW-1]};
  assign take    = (shifted >= {2'b00, dmag_q});

  // Signed results formed from the magnitudes once the iterations finish.
  logic          div_by_zero;
  logic [DW-1:0] fix_quot;
  logic [VW-1:0] fix_rem;
  logic          fix_ovf;
  assign div_by_zero = (dmag_q == '0);

  always_comb begin
    fix_quot = neg_quot_q ? -dq_q : dq_q;
    fix_rem  = neg_rem_q ? -rem_q[VW-1:0] : rem_q[VW-1:0];
    // A positive quotient with its MSB set cannot be represented. This only
    // happens for -2^(DW-1) / -1.
    fix_ovf  = ~neg_quot_q & dq_q[DW-1];
    if (div_by_zero) begin
      fix_quot = '0;
      fix_rem  = '0;
      fix_ovf  = 1'b0;
    end
  end

`ifdef DIVIDER_BCD_OUT_EN
  localparam int ND = ((DW - 1) * 301) / 1000 + 1;

  logic [4*ND-1:0] bcd_q, bcd_d;
  logic [4*ND-1:0] bcd_adj;
  logic [4*ND-1:0] bcd_shift;
  logic [DW-1:0]   bin_q, bin_d;
  logic [4*ND-1:0] quot_bcd_q, quot_bcd_d;
  logic            quot_sign_q, quot_sign_d;

  // Each digit >= 5 gets +3 before the shift, so it carries correctly.
  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_add3
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
    end
  endgenerate

  // The top digit never overflows for magnitudes up to 2^(DW-1).
  assign bcd_shift = (4*ND)'({bcd_adj, bin_q[DW-1]});
`endif

  logic publish;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dq_d        = dq_q;
    dmag_d      = dmag_q;
    rem_d       = rem_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    publish     = 1'b0;
`ifdef DIVIDER_BCD_OUT_EN
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    quot_bcd_d  = quot_bcd_q;
    quot_sign_d = quot_sign_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dq_d       = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
          dmag_d     = bus.divisor[VW-1] ? -bus.divisor : bus.divisor;
          rem_d      = '0;
          neg_quot_d = bus.dividend[DW-1] ^ bus.divisor[VW-1];
          neg_rem_d  = bus.dividend[DW-1];
          cnt_d      = CW'(DW - 1);
          state_d    = S_ITER;
        end
      end

      S_ITER: begin
        rem_d = take ? RW'(shifted - {2'b00, dmag_q}) : RW'(shifted);
        dq_d  = {dq_q[DW-2:0], take};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_FIX: begin
`ifdef DIVIDER_BCD_OUT_EN
        bin_d   = dq_q;
        bcd_d   = '0;
        cnt_d   = CW'(DW - 1);
        state_d = S_BCD;
`else
        publish = 1'b1;
        state_d = S_IDLE;
`endif
      end

      S_BCD: begin
`ifdef DIVIDER_BCD_OUT_EN
        bcd_d = bcd_shift;
        bin_d = {bin_q[DW-2:0], 1'b0};
        if (cnt_q == '0) begin
          publish = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase

    if (publish) begin
      done_d      = 1'b1;
      quotient_d  = fix_quot;
      remainder_d = fix_rem;
      div_zero_d  = div_by_zero;
      overflow_d  = fix_ovf;
`ifdef DIVIDER_BCD_OUT_EN
      quot_bcd_d  = div_by_zero ? '0 : bcd_shift;
      // A zero quotient is shown without a minus sign.
      quot_sign_d = neg_quot_q & ~div_by_zero & (|dq_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dq_q        <= '0;
      dmag_q      <= '0;
      rem_q       <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef DIVIDER_BCD_OUT_EN
      bcd_q       <= '0;
      bin_q       <= '0;
      quot_bcd_q  <= '0;
      quot_sign_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dq_q        <= dq_d;
      dmag_q      <= dmag_d;
      rem_q       <= rem_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
`ifdef DIVIDER_BCD_OUT_EN
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      quot_bcd_q  <= quot_bcd_d;
      quot_sign_q <= quot_sign_d;
`endif
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.overflow  = overflow_q;
`ifdef DIVIDER_BCD_OUT_EN
  assign bus.quot_bcd  = quot_bcd_q;
  assign bus.quot_sign = quot_sign_q;
`endif
endmodule

// File: tb/tb_signed_divider.sv
// -----------------------------------------------------------------------------
// tb_signed_divider
//   Self-checking bench for signed_divider (DW=10, VW=5). Expected results come
//   from plain integer / and % in a reference model. Covers reset, the
//   directed sign, zero and overflow cases, handshake corner cases, a reset
//   during a division, and random operands.
//   Honours DIVIDER_BCD_OUT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_signed_divider;
  localparam int DW = 10;
  localparam int VW = 5;
`ifdef DIVIDER_BCD_OUT_EN
  localparam int LAT = 2*DW + 2;
`else
  localparam int LAT = DW + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  signed_divider_if #(.DW(DW), .VW(VW)) bus_if ();

  signed_divider #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division with a remainder signed like the dividend.
  task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       output logic [DW-1:0] q, output logic [VW-1:0] r,
                       output logic z, output logic o,
                       output logic [11:0] bcd, output logic s);
    int ai, bi, qi, ri, m;
    ai = $signed(a);
    bi = $signed(b);
    if (bi == 0) begin
      q = '0; r = '0; z = 1'b1; o = 1'b0; bcd = '0; s = 1'b0;
    end else begin
      qi  = ai / bi;
      ri  = ai % bi;
      q   = qi[DW-1:0];
      r   = ri[VW-1:0];
      z   = 1'b0;
      o   = (qi > 511);
      m   = (qi < 0) ? -qi : qi;
      bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
      s   = (qi < 0);
    end
  endtask

  // Waits for done after the capture edge (edge 1). Returns edges counted.
  task automatic wait_done(output int n);
    n = 1;
    while (bus_if.done !== 1'b1 && n < LAT + 4) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_results(input logic [DW-1:0] a, input logic [VW-1:0] b,
                               input string tag);
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic z, o, s;
    logic [11:0] bcd;
    model(a, b, q, r, z, o, bcd, s);
    check_val({tag, "_quotient"}, bus_if.quotient, q);
    check_val({tag, "_remainder"}, bus_if.remainder, r);
    check_val({tag, "_div_zero"}, bus_if.div_zero, z);
    check_val({tag, "_overflow"}, bus_if.overflow, o);
`ifdef DIVIDER_BCD_OUT_EN
    check_val({tag, "_quot_bcd"}, bus_if.quot_bcd, bcd);
    check_val({tag, "_quot_sign"}, bus_if.quot_sign, s);
`endif
    $display("op %0d / %0d -> q=%0d r=%0d dz=%0b ovf=%0b", $signed(a), $signed(b),
             $signed(bus_if.quotient), $signed(bus_if.remainder),
             bus_if.div_zero, bus_if.overflow);
  endtask

  // One full division with start pulsed for a single cycle.
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int n;
    bus_if.start    = 1'b1;
    bus_if.dividend = a;
    bus_if.divisor  = b;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    check_val("busy_after_start", bus_if.busy, 1'b1);
    wait_done(n);
    check_val("latency", n, LAT);
    check_val("busy_in_done", bus_if.busy, 1'b0);
    check_results(a, b, "op");
    @(posedge clk); #1;
    check_val("done_pulse_width", bus_if.done, 1'b0);
  endtask

  int da [8] = '{100, -100, 100, -100, 37, 9, -512, -512};
  int db [8] = '{7, 7, -7, -7, 0, 3, -1, 1};

  initial begin
    int n;
    int dones;
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;

    bus_if.start    = 1'b0;
    bus_if.dividend = '0;
    bus_if.divisor  = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", bus_if.busy, 1'b0);
    check_val("rst_done", bus_if.done, 1'b0);
    check_val("rst_quotient", bus_if.quotient, '0);
    check_val("rst_remainder", bus_if.remainder, '0);
    check_val("rst_div_zero", bus_if.div_zero, 1'b0);
    check_val("rst_overflow", bus_if.overflow, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed: signs, divide-by-zero then flag clear, overflow boundary.
    for (int i = 0; i < 8; i++) begin
      run_op(DW'(da[i]), VW'(db[i]));
    end

    // start pulsed while busy must be ignored.
    bus_if.start    = 1'b1;
    bus_if.dividend = DW'(55);
    bus_if.divisor  = VW'(6);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus_if.start    = 1'b1;
    bus_if.dividend = DW'(-3);
    bus_if.divisor  = VW'(2);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.dividend = DW'(55);
    bus_if.divisor  = VW'(6);
    n = 4;
    while (bus_if.done !== 1'b1 && n < LAT + 4) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("busy_start_latency", n, LAT);
    check_results(DW'(55), VW'(6), "busy_start");
    dones = 0;
    repeat (LAT + 2) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) dones++;
    end
    check_val("busy_start_no_extra_done", dones, 0);

    // start held through the done cycle: back-to-back divisions.
    bus_if.start    = 1'b1;
    bus_if.dividend = DW'(100);
    bus_if.divisor  = VW'(7);
    @(posedge clk); #1;
    wait_done(n);
    check_val("b2b_first_latency", n, LAT);
    check_results(DW'(100), VW'(7), "b2b_first");
    bus_if.dividend = DW'(-77);
    bus_if.divisor  = VW'(5);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    wait_done(n);
    check_val("b2b_second_latency", n, LAT);
    check_results(DW'(-77), VW'(5), "b2b_second");
    @(posedge clk); #1;

    // Reset during a division: no done, everything back to 0.
    bus_if.start    = 1'b1;
    bus_if.dividend = DW'(123);
    bus_if.divisor  = VW'(4);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_val("midrst_busy", bus_if.busy, 1'b0);
    check_val("midrst_quotient", bus_if.quotient, '0);
    check_val("midrst_remainder", bus_if.remainder, '0);
    check_val("midrst_flags", {bus_if.div_zero, bus_if.overflow}, 2'b00);
`ifdef DIVIDER_BCD_OUT_EN
    check_val("midrst_quot_bcd", bus_if.quot_bcd, '0);
    check_val("midrst_quot_sign", bus_if.quot_sign, 1'b0);
`endif
    dones = 0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) dones++;
    end
    check_val("midrst_no_done", dones, 0);

    // Random operands, with the most negative dividend mixed in.
    for (int i = 0; i < 150; i++) begin
      ra = DW'($urandom_range(0, 1023));
      rb = VW'($urandom_range(0, 31));
      if (i % 10 == 0) ra = 10'h200;
      if (i % 25 == 0) rb = 5'h1F;
      run_op(ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
